loop_sequencer: RTL and testbench

LOOP_SEQUENCER -- requirements
Module: loop_sequencer

---
 rtl/loop_sequencer_if.sv | 27 ++
 rtl/loop_sequencer.sv | 105 ++++++++++
 tb/tb_loop_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/loop_sequencer_if.sv
// Handshake and counter-bus bundle between the loop sequencer, its requester,
// the stepping datapath and the external up/down counter.
interface loop_sequencer_if #(
    parameter int W = 6
);
    logic         start;
    logic         mode;
    logic [W-1:0] n_in;
    logic         abort;
    logic         step_ack;
    logic [W-1:0] cnt_val;
    logic [2:0]   cnt_ctrl;
    logic [W-1:0] cnt_data;
    logic         step_req;
    logic         busy;
    logic         done;

    modport master (
        output start, mode, n_in, abort, step_ack, cnt_val,
        input  cnt_ctrl, cnt_data, step_req, busy, done
    );

    modport slave (
        input  start, mode, n_in, abort, step_ack, cnt_val,
        output cnt_ctrl, cnt_data, step_req, busy, done
    );
endinterface

// File: rtl/loop_sequencer.sv
// Loop sequencer: commands an external counter through n up/down steps, one
// datapath step per RUN visit, and pulses done when the counter hits target.
module loop_sequencer #(
    parameter int W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    loop_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        STEP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [2:0] CTRL_HOLD = 3'b000;
    localparam logic [2:0] CTRL_LOAD = 3'b100;
    localparam logic [2:0] CTRL_INC  = 3'b010;
    localparam logic [2:0] CTRL_DEC  = 3'b011;

    state_t         state_q, state_d;
    logic           mode_q, mode_d;
    logic [W-1:0]   n_q, n_d;
    logic [W-1:0]   cnt_data_q, cnt_data_d;
    logic [W-1:0]   target;
    logic           at_target;

    assign target    = mode_q ? n_q : '0;
    assign at_target = (bus.cnt_val == target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            n_q        <= '0;
            cnt_data_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            n_q        <= n_d;
            cnt_data_q <= cnt_data_d;
        end
    end

    // Abort overrides every transition out of a busy state, including a pending step_ack.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        n_d     = n_q;
        if ((state_q != IDLE) && bus.abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = LOAD;
                        mode_d  = bus.mode;
                        n_d     = bus.n_in;
                    end
                end
                LOAD:    state_d = SETTLE;
                SETTLE:  state_d = at_target ? DONE : RUN;
                RUN: begin
                    if (bus.step_ack) begin
                        state_d = STEP;
                    end
                end
                STEP:    state_d = SETTLE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // The load value is registered on entry to LOAD so it holds steady afterwards.
    always_comb begin
        cnt_data_d = cnt_data_q;
        if (state_d == LOAD) begin
            cnt_data_d = mode_d ? '0 : n_d;
        end
    end

    always_comb begin
        bus.cnt_ctrl = CTRL_HOLD;
        bus.step_req = 1'b0;
        bus.busy     = 1'b1;
        bus.done     = 1'b0;
        unique case (state_q)
            IDLE:    bus.busy     = 1'b0;
            LOAD:    bus.cnt_ctrl = CTRL_LOAD;
            SETTLE:  bus.cnt_ctrl = CTRL_HOLD;
            RUN:     bus.step_req = 1'b1;
            STEP:    bus.cnt_ctrl = mode_q ? CTRL_INC : CTRL_DEC;
            DONE:    bus.done     = 1'b1;
            default: bus.busy     = 1'b0;
        endcase
    end

    assign bus.cnt_data = cnt_data_q;

endmodule

// File: tb/tb_loop_sequencer.sv
// Scoreboard bench for loop_sequencer: a behavioural counter and ack responder
// close the loop; per-loop expectations and counter trajectories are queued at start.
module tb_loop_sequencer;

    localparam int W = 6;
    localparam int KIND_NORMAL = 0;
    localparam int KIND_ABORT  = 1;
    localparam int KIND_RESET  = 2;

    typedef struct {
        int req;
        int inc;
        int dec;
        int done;
        int final_val;
        bit full_check;
    } exp_t;

    logic clk;
    logic rst_n;
    loop_sequencer_if #(.W(W)) bus ();

    loop_sequencer #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   check_count = 0;
    int   error_count = 0;
    int   ack_mode    = 0;
    exp_t sb_q[$];
    int   val_q[$];

    logic [W-1:0] cnt_model;
    assign bus.cnt_val = cnt_model;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // External counter obeying the sequencer's commands.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_model <= '0;
        else begin
            case (bus.cnt_ctrl)
                3'b100:  cnt_model <= bus.cnt_data;
                3'b010:  cnt_model <= cnt_model + 1'b1;
                3'b011:  cnt_model <= cnt_model - 1'b1;
                default: cnt_model <= cnt_model;
            endcase
        end
    end

    // Ack responder: mode 1 answers one cycle into each RUN visit, mode 2 holds ack high.
    initial begin
        logic req_prev;
        req_prev     = 1'b0;
        bus.step_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.step_ack = (ack_mode == 2) || ((ack_mode == 1) && bus.step_req && req_prev);
            req_prev     = bus.step_req;
        end
    end

    // Monitor: counts commands per loop, checks the counter trajectory, scores each loop at busy fall.
    initial begin
        logic       prev_busy, prev_done, prev_req;
        logic [2:0] prev_ctrl;
        int         mon_req, mon_inc, mon_dec, mon_done;
        exp_t       e;
        prev_busy = 1'b0; prev_done = 1'b0; prev_req = 1'b0; prev_ctrl = 3'b000;
        mon_req = 0; mon_inc = 0; mon_dec = 0; mon_done = 0;
        forever begin
            @(negedge clk);
            if (prev_done) checkOutput("busy_after_done", 32'(bus.busy), 0);
            if (rst_n && (prev_ctrl == 3'b100 || prev_ctrl == 3'b010 || prev_ctrl == 3'b011)) begin
                if (val_q.size() == 0) checkOutput("cnt_val_extra", 32'(bus.cnt_val), 32'hFFFF_FFFF);
                else checkOutput("cnt_val", 32'(bus.cnt_val), 32'(val_q.pop_front()));
            end
            if (bus.step_req && !prev_req) mon_req++;
            if (bus.cnt_ctrl == 3'b010) mon_inc++;
            if (bus.cnt_ctrl == 3'b011) mon_dec++;
            if (bus.done) mon_done++;
            if (prev_busy && !bus.busy) begin
                if (sb_q.size() == 0) begin
                    checkOutput("loop_queue", 32'(sb_q.size()), 1);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("req_count",  32'(mon_req),  32'(e.req));
                    checkOutput("inc_count",  32'(mon_inc),  32'(e.inc));
                    checkOutput("dec_count",  32'(mon_dec),  32'(e.dec));
                    checkOutput("done_count", 32'(mon_done), 32'(e.done));
                    checkOutput("final_cnt",  32'(bus.cnt_val), 32'(e.final_val));
                    if (e.full_check) checkOutput("leftover_vals", 32'(val_q.size()), 0);
                end
                val_q.delete();
                mon_req = 0; mon_inc = 0; mon_dec = 0; mon_done = 0;
            end
            prev_busy = bus.busy;
            prev_done = bus.done;
            prev_req  = bus.step_req;
            prev_ctrl = rst_n ? bus.cnt_ctrl : 3'b000;
        end
    end

    // Called at negedge+1 while idle; returns at negedge+1 of the LOAD cycle.
    task automatic applyStimulus(input logic m, input logic [W-1:0] n, input int kind);
        exp_t e;
        int   ni;
        ni = int'(n);
        e.req = ni; e.inc = m ? ni : 0; e.dec = m ? 0 : ni; e.done = 1;
        e.final_val = m ? ni : 0; e.full_check = 1'b1;
        if (kind == KIND_ABORT) begin
            e.req = 1; e.inc = 0; e.dec = 0; e.done = 0; e.final_val = m ? 0 : ni; e.full_check = 1'b0;
        end else if (kind == KIND_RESET) begin
            e.req = 1; e.inc = m ? 1 : 0; e.dec = m ? 0 : 1; e.done = 0; e.final_val = 0; e.full_check = 1'b0;
        end
        sb_q.push_back(e);
        for (int i = 0; i <= ni; i++) val_q.push_back(m ? i : ni - i);
        bus.start = 1'b1; bus.mode = m; bus.n_in = n;
        @(negedge clk); #1;
        bus.start = 1'b0;
        checkOutput("load_ctrl", 32'(bus.cnt_ctrl), 32'h4);
        checkOutput("load_data", 32'(bus.cnt_data), m ? 0 : 32'(n));
        checkOutput("load_busy", 32'(bus.busy), 1);
        checkOutput("load_req",  32'(bus.step_req), 0);
    endtask

    task automatic waitIdle(input int limit);
        bit timed_out;
        timed_out = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk); #1;
            if (!bus.busy && sb_q.size() == 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        checkOutput("idle_timeout", 32'(timed_out), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.mode = 1'b0; bus.n_in = '0; bus.abort = 1'b0;
        #1;
        checkOutput("rst_ctrl", 32'(bus.cnt_ctrl), 0);
        checkOutput("rst_data", 32'(bus.cnt_data), 0);
        checkOutput("rst_req",  32'(bus.step_req), 0);
        checkOutput("rst_busy", 32'(bus.busy), 0);
        checkOutput("rst_done", 32'(bus.done), 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;

        ack_mode = 1;
        applyStimulus(1'b0, 6'd3, KIND_NORMAL);
        waitIdle(100);
        applyStimulus(1'b1, 6'd2, KIND_NORMAL);
        waitIdle(100);

        for (int m = 0; m < 2; m++) begin
            applyStimulus(m[0], 6'd0, KIND_NORMAL);
            checkOutput("n0_done_c1", 32'(bus.done), 0);
            @(negedge clk); #1;
            checkOutput("n0_done_c2", 32'(bus.done), 0);
            @(negedge clk); #1;
            checkOutput("n0_done_c3", 32'(bus.done), 1);
            waitIdle(20);
        end

        // Max count with ack tied high, plus a start/mode/n change while busy.
        ack_mode = 2;
        applyStimulus(1'b0, 6'd63, KIND_NORMAL);
        bus.start = 1'b1; bus.mode = 1'b1; bus.n_in = 6'd5;
        repeat (8) @(negedge clk);
        #1 bus.start = 1'b0;
        waitIdle(400);
        applyStimulus(1'b1, 6'd63, KIND_NORMAL);
        waitIdle(400);

        // Abort in RUN while step_ack is also high.
        applyStimulus(1'b0, 6'd5, KIND_ABORT);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.step_req) begin seen = 1'b1; break; end
            @(negedge clk); #1;
        end
        checkOutput("abort_reach_run", 32'(seen), 1);
        bus.abort = 1'b1;
        @(negedge clk); #1;
        bus.abort = 1'b0;
        checkOutput("abort_busy", 32'(bus.busy), 0);
        checkOutput("abort_done", 32'(bus.done), 0);
        checkOutput("abort_ctrl", 32'(bus.cnt_ctrl), 0);
        waitIdle(20);

        // Reset pulse during the first STEP, then a fresh single-step loop.
        ack_mode = 1;
        applyStimulus(1'b0, 6'd3, KIND_RESET);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.cnt_ctrl == 3'b011) begin seen = 1'b1; break; end
            @(negedge clk); #1;
        end
        checkOutput("reset_reach_step", 32'(seen), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ctrl", 32'(bus.cnt_ctrl), 0);
        checkOutput("midrst_data", 32'(bus.cnt_data), 0);
        checkOutput("midrst_req",  32'(bus.step_req), 0);
        checkOutput("midrst_busy", 32'(bus.busy), 0);
        checkOutput("midrst_done", 32'(bus.done), 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        waitIdle(20);
        applyStimulus(1'b1, 6'd1, KIND_NORMAL);
        waitIdle(50);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
